// File: rtl/capture_dump_pkg.sv
// Shared types and helpers for the capture_dump logic-capture buffer.
package capture_dump_pkg;

  typedef enum logic [1:0] {
    ARMED = 2'd0,
    POST  = 2'd1,
    DUMP  = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h41 + {4'h0, nib} - 8'd10);
  endfunction

endpackage

// File: rtl/capture_dump_if.sv
// Byte-wide transmit handshake between the capture buffer and the UART transmitter.
interface capture_dump_if;
  logic [7:0] tx_dat;
  logic       tx_start;
  logic       tx_busy;

  modport master (output tx_dat, output tx_start, input tx_busy);
  modport slave  (input tx_dat, input tx_start, output tx_busy);
endinterface

// File: rtl/dump_serializer.sv
// Turns buffered words into UART bytes (binary or ASCII hex + CR/LF) and
// paces tx_start against tx_busy with a one-cycle holdoff after each start.
module dump_serializer
  import capture_dump_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] word,
  input  logic              word_vld,
  input  logic              last_word,
  input  logic              hex_mode,
  input  logic              tx_busy,
  output logic [7:0]        tx_dat,
  output logic              tx_start,
  output logic              word_taken,
  output logic              last_byte_sent
);

  localparam int NBYTES = WORD_W / 8;
  localparam int NCHARS = WORD_W / 4;
  localparam int IDX_W  = $clog2(NCHARS + 2);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       tx_dat_q, tx_dat_d;
  logic             tx_start_q, tx_start_d;
  logic             hold_q, hold_d;
  logic             drain_q, drain_d;
  logic [IDX_W-1:0] idx_last;
  logic [7:0]       cur_byte;
  logic             tx_free;

  always_comb begin
    idx_last = hex_mode ? IDX_W'(NCHARS + 1) : IDX_W'(NBYTES - 1);
    if (!hex_mode)
      cur_byte = 8'(word >> (WORD_W - 8 - 8 * idx_q));
    else if (idx_q == IDX_W'(NCHARS))
      cur_byte = ASCII_CR;
    else if (idx_q == IDX_W'(NCHARS + 1))
      cur_byte = ASCII_LF;
    else
      cur_byte = nib2ascii(4'(word >> (WORD_W - 4 - 4 * idx_q)));

    // The start cycle itself and the holdoff cycle after it never issue.
    tx_free        = !tx_start_q && !hold_q && !tx_busy;
    tx_start_d     = word_vld && !drain_q && tx_free;
    tx_dat_d       = tx_start_d ? cur_byte : tx_dat_q;
    hold_d         = tx_start_q;
    idx_d          = idx_q;
    drain_d        = drain_q;
    word_taken     = 1'b0;
    last_byte_sent = 1'b0;

    if (tx_start_d) begin
      if (idx_q == idx_last) begin
        idx_d      = '0;
        word_taken = 1'b1;
        drain_d    = last_word;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    if (drain_q && tx_free) begin
      last_byte_sent = 1'b1;
      drain_d        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      tx_dat_q   <= '0;
      tx_start_q <= 1'b0;
      hold_q     <= 1'b0;
      drain_q    <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      tx_dat_q   <= tx_dat_d;
      tx_start_q <= tx_start_d;
      hold_q     <= hold_d;
      drain_q    <= drain_d;
    end
  end

  assign tx_dat   = tx_dat_q;
  assign tx_start = tx_start_q;

endmodule

// File: rtl/capture_dump.sv
// 1-bit logic-capture buffer: decimated sampling into a circular word RAM,
// trigger with post-trigger window, then a full-buffer dump to the UART.
module capture_dump
  import capture_dump_pkg::*;
#(
  parameter int WORD_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int POST_WORDS = 128,
  parameter int DECIM_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sig,
  input  logic               trig,
  input  logic [DECIM_W-1:0] decim,
  input  logic               hex_mode,
  capture_dump_if.master     tx,
  output logic               armed,
  output logic               done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int BIT_W = $clog2(WORD_W);
  localparam int CNT_W = ADDR_W + 1;

  if ((WORD_W % 8) != 0 || WORD_W < 8 || WORD_W > 32) begin : g_bad_word_w
    $error("capture_dump: WORD_W must be a multiple of 8 in 8..32");
  end
  if (POST_WORDS < 0 || POST_WORDS > DEPTH) begin : g_bad_post_words
    $error("capture_dump: POST_WORDS must lie in 0..2**ADDR_W");
  end

  state_t              state_q, state_d;
  logic                trig_d_q, trig_d_d;
  logic [DECIM_W-1:0]  dec_cnt_q, dec_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WORD_W-2:0]   shift_q, shift_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]    post_cnt_q, post_cnt_d;
  logic                rd_pend_q, rd_pend_d;
  logic [WORD_W-1:0]   buf_q, buf_d;
  logic                buf_vld_q, buf_vld_d;
  logic                mode_q, mode_d;
  logic                armed_q, armed_d;
  logic                done_q, done_d;

  logic                sampling, tick, trig_edge;
  logic                ram_we, ram_re;
  logic [WORD_W-1:0]   ram_wdata, ram_q;
  logic [WORD_W-1:0]   mem [DEPTH];

  logic [7:0]          ser_dat;
  logic                ser_start, word_taken, last_byte_sent, last_word;

  always_comb begin
    sampling  = (state_q != DUMP);
    tick      = sampling && (dec_cnt_q == decim);
    ram_we    = tick && (bit_cnt_q == BIT_W'(WORD_W - 1));
    ram_wdata = {shift_q, sig};
    trig_edge = trig && !trig_d_q;
    last_word = (rd_cnt_q == CNT_W'(DEPTH));

    state_d    = state_q;
    trig_d_d   = trig;
    dec_cnt_d  = dec_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_cnt_d   = rd_cnt_q;
    post_cnt_d = post_cnt_q;
    rd_pend_d  = rd_pend_q;
    buf_d      = buf_q;
    buf_vld_d  = buf_vld_q;
    mode_d     = mode_q;
    done_d     = 1'b0;
    ram_re     = 1'b0;

    if (sampling) begin
      dec_cnt_d = tick ? '0 : dec_cnt_q + 1'b1;
      rd_cnt_d  = '0;
      rd_pend_d = 1'b0;
      buf_vld_d = 1'b0;
      if (tick) begin
        shift_d   = ram_wdata[WORD_W-2:0];
        bit_cnt_d = ram_we ? '0 : bit_cnt_q + 1'b1;
      end
      if (ram_we)
        wr_ptr_d = wr_ptr_q + 1'b1;
    end

    // After the last post-trigger write, wr_ptr points at the oldest word.
    case (state_q)
      ARMED: begin
        if (trig_edge) begin
          mode_d     = hex_mode;
          post_cnt_d = '0;
          if (POST_WORDS == 0) begin
            state_d  = DUMP;
            rd_ptr_d = wr_ptr_d;
          end else begin
            state_d = POST;
          end
        end
      end
      POST: begin
        if (ram_we)
          post_cnt_d = post_cnt_q + 1'b1;
        if (post_cnt_d == CNT_W'(POST_WORDS)) begin
          state_d  = DUMP;
          rd_ptr_d = wr_ptr_d;
        end
      end
      DUMP: begin
        rd_pend_d = 1'b0;
        if (rd_pend_q) begin
          buf_d     = ram_q;
          buf_vld_d = 1'b1;
        end
        if (word_taken)
          buf_vld_d = 1'b0;
        if (!buf_vld_q && !rd_pend_q && !last_word) begin
          ram_re    = 1'b1;
          rd_pend_d = 1'b1;
          rd_ptr_d  = rd_ptr_q + 1'b1;
          rd_cnt_d  = rd_cnt_q + 1'b1;
        end
        if (last_byte_sent) begin
          state_d   = ARMED;
          done_d    = 1'b1;
          dec_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      default: state_d = ARMED;
    endcase

    armed_d = (state_d == ARMED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARMED;
      trig_d_q   <= 1'b0;
      dec_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_cnt_q   <= '0;
      post_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      buf_q      <= '0;
      buf_vld_q  <= 1'b0;
      mode_q     <= 1'b0;
      armed_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      trig_d_q   <= trig_d_d;
      dec_cnt_q  <= dec_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_cnt_q   <= rd_cnt_d;
      post_cnt_q <= post_cnt_d;
      rd_pend_q  <= rd_pend_d;
      buf_q      <= buf_d;
      buf_vld_q  <= buf_vld_d;
      mode_q     <= mode_d;
      armed_q    <= armed_d;
      done_q     <= done_d;
    end
  end

  // Write and read never overlap (sampling vs. dump), so a single-port-style block RAM fits.
  always_ff @(posedge clk) begin
    if (ram_we)
      mem[wr_ptr_q] <= ram_wdata;
    if (ram_re)
      ram_q <= mem[rd_ptr_q];
  end

  dump_serializer #(
    .WORD_W(WORD_W)
  ) u_serializer (
    .clk            (clk),
    .rst            (rst),
    .word           (buf_q),
    .word_vld       (buf_vld_q),
    .last_word      (last_word),
    .hex_mode       (mode_q),
    .tx_busy        (tx.tx_busy),
    .tx_dat         (ser_dat),
    .tx_start       (ser_start),
    .word_taken     (word_taken),
    .last_byte_sent (last_byte_sent)
  );

  assign tx.tx_dat   = ser_dat;
  assign tx.tx_start = ser_start;
  assign armed       = armed_q;
  assign done        = done_q;

endmodule

// File: tb/tb_capture_dump.sv
// Directed testbench for capture_dump (WORD_W=16, ADDR_W=4, POST_WORDS=8).
module tb_capture_dump;

  localparam int WORD_W     = 16;
  localparam int ADDR_W     = 4;
  localparam int POST_WORDS = 8;
  localparam int DECIM_W    = 8;
  localparam int BUDGET     = 20000;

  logic               clk      = 1'b0;
  logic               rst      = 1'b1;
  logic               sig      = 1'b0;
  logic               trig     = 1'b0;
  logic               hex_mode = 1'b0;
  logic [DECIM_W-1:0] decim    = '0;
  logic               armed, done;
  logic               busy_r   = 1'b0;

  capture_dump_if tx_if ();
  assign tx_if.tx_busy = busy_r;

  capture_dump #(
    .WORD_W(WORD_W), .ADDR_W(ADDR_W), .POST_WORDS(POST_WORDS), .DECIM_W(DECIM_W)
  ) dut (
    .clk(clk), .rst(rst), .sig(sig), .trig(trig), .decim(decim),
    .hex_mode(hex_mode), .tx(tx_if), .armed(armed), .done(done)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         samp = 0;
  bit         pat_beef = 1'b0;
  int         busy_len = 0;
  int         busy_left = 0;
  bit         start_pend = 1'b0;
  bit         prev_start = 1'b0;
  int         busy_err = 0;
  int         wide_err = 0;
  int         done_cnt = 0;
  logic [7:0] rx_q[$];

  // Byte monitor plus UART model: busy for busy_len clocks starting 1 clk after each start.
  always @(negedge clk) begin
    if (tx_if.tx_start === 1'b1) begin
      rx_q.push_back(tx_if.tx_dat);
      if (prev_start) wide_err++;
      if (busy_r) busy_err++;
    end
    prev_start = (tx_if.tx_start === 1'b1);
    if (done === 1'b1) done_cnt++;
    if (busy_left > 0) begin
      busy_left--;
      busy_r = (busy_left > 0);
    end
    if (start_pend && busy_len > 0) begin
      busy_r    = 1'b1;
      busy_left = busy_len;
    end
    start_pend = (tx_if.tx_start === 1'b1);
  end

  task automatic set_sig();
    logic [15:0] w;
    w   = pat_beef ? 16'hBEEF : 16'(samp / 16);
    sig = w[15 - (samp % 16)];
    samp++;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    set_sig();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1;
    rst  = 1'b1;
    trig = 1'b0;
    repeat (n) @(negedge clk);
    #1;
    rst  = 1'b0;
    samp = 0;
    set_sig();
  endtask

  task automatic run_until_done(input int budget);
    int d;
    d = done_cnt;
    for (int i = 0; i < budget && done_cnt == d; i++) step();
  endtask

  task automatic test_reset();
    do_reset(3);
    checks++; if (armed !== 1'b1) begin errors++; $display("[TB] FAIL reset_armed: got %b expected 1", armed); end
    checks++; if (tx_if.tx_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_start: got %b expected 0", tx_if.tx_start); end
    checks++; if (tx_if.tx_dat !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_dat: got %h expected 00", tx_if.tx_dat); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    rx_q.delete();
    repeat (40) step();
    checks++; if (rx_q.size() != 0) begin errors++; $display("[TB] FAIL idle_no_tx: got %0d bytes expected 0", rx_q.size()); end
  endtask

  task automatic test_binary_dump();
    int d0;
    busy_len = 0; hex_mode = 1'b0; pat_beef = 1'b0; decim = 8'd0;
    do_reset(2);
    rx_q.delete(); d0 = done_cnt;
    repeat (320) step();
    trig = 1'b1;
    repeat (2) step();
    checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL bin_armed_after_trig: got %b expected 0", armed); end
    run_until_done(BUDGET);
    checks++; if (done_cnt != d0 + 1) begin errors++; $display("[TB] FAIL bin_done_timeout: got %0d expected %0d", done_cnt - d0, 1); end
    checks++; if (rx_q.size() != 32) begin errors++; $display("[TB] FAIL bin_byte_count: got %0d expected 32", rx_q.size()); end
    for (int i = 0; i < 16 && rx_q.size() == 32; i++) begin
      checks++; if (rx_q[2*i] !== 8'h00) begin errors++; $display("[TB] FAIL bin_hi_byte[%0d]: got %h expected 00", i, rx_q[2*i]); end
      checks++; if (rx_q[2*i+1] !== 8'(12 + i)) begin errors++; $display("[TB] FAIL bin_lo_byte[%0d]: got %h expected %h", i, rx_q[2*i+1], 8'(12 + i)); end
    end
    repeat (5) step();
    checks++; if (done_cnt != d0 + 1) begin errors++; $display("[TB] FAIL bin_done_once: got %0d expected 1", done_cnt - d0); end
    checks++; if (armed !== 1'b1) begin errors++; $display("[TB] FAIL bin_armed_after_done: got %b expected 1", armed); end
    trig = 1'b0;
  endtask

  task automatic test_hex_dump();
    logic [7:0] exp_grp [6];
    exp_grp = '{8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    busy_len = 0; hex_mode = 1'b1; pat_beef = 1'b1; decim = 8'd0;
    do_reset(2);
    rx_q.delete();
    repeat (320) step();
    trig = 1'b1;
    repeat (3) step();
    hex_mode = 1'b0;
    run_until_done(BUDGET);
    checks++; if (rx_q.size() != 96) begin errors++; $display("[TB] FAIL hex_byte_count: got %0d expected 96", rx_q.size()); end
    for (int i = 0; i < 96 && rx_q.size() == 96; i++) begin
      checks++; if (rx_q[i] !== exp_grp[i % 6]) begin errors++; $display("[TB] FAIL hex_byte[%0d]: got %h expected %h", i, rx_q[i], exp_grp[i % 6]); end
    end
    trig = 1'b0; pat_beef = 1'b0;
  endtask

  task automatic test_busy_handshake();
    busy_len = 100; hex_mode = 1'b0; pat_beef = 1'b0; decim = 8'd0;
    do_reset(2);
    rx_q.delete(); busy_err = 0; wide_err = 0;
    repeat (320) step();
    trig = 1'b1;
    run_until_done(BUDGET);
    checks++; if (rx_q.size() != 32) begin errors++; $display("[TB] FAIL busy_byte_count: got %0d expected 32", rx_q.size()); end
    for (int i = 0; i < 16 && rx_q.size() == 32; i++) begin
      checks++; if ({rx_q[2*i], rx_q[2*i+1]} !== 16'(12 + i)) begin errors++; $display("[TB] FAIL busy_word[%0d]: got %h%h expected %h", i, rx_q[2*i], rx_q[2*i+1], 16'(12 + i)); end
    end
    checks++; if (busy_err != 0) begin errors++; $display("[TB] FAIL busy_start_while_busy: got %0d expected 0", busy_err); end
    checks++; if (wide_err != 0) begin errors++; $display("[TB] FAIL busy_start_width: got %0d expected 0", wide_err); end
    trig = 1'b0; busy_len = 0;
  endtask

  task automatic test_decim();
    int wr_t[$];
    for (int m = 0; m < 2; m++) begin
      int period;
      period = (m == 0) ? 64 : 16;
      decim  = (m == 0) ? 8'd3 : 8'd0;
      do_reset(2);
      wr_t.delete();
      for (int c = 0; c < 3 * period + 8; c++) begin
        if (dut.ram_we === 1'b1) wr_t.push_back(c);
        step();
      end
      checks++; if (wr_t.size() != 3) begin errors++; $display("[TB] FAIL decim%0d_write_count: got %0d expected 3", decim, wr_t.size()); end
      if (wr_t.size() == 3) begin
        checks++; if (wr_t[0] != period - 1) begin errors++; $display("[TB] FAIL decim%0d_first_write: got %0d expected %0d", decim, wr_t[0], period - 1); end
        checks++; if (wr_t[1] - wr_t[0] != period) begin errors++; $display("[TB] FAIL decim%0d_interval1: got %0d expected %0d", decim, wr_t[1] - wr_t[0], period); end
        checks++; if (wr_t[2] - wr_t[1] != period) begin errors++; $display("[TB] FAIL decim%0d_interval2: got %0d expected %0d", decim, wr_t[2] - wr_t[1], period); end
      end
    end
    decim = 8'd0;
  endtask

  task automatic test_trig_hold();
    int d0;
    busy_len = 0; hex_mode = 1'b0; pat_beef = 1'b0; decim = 8'd0;
    do_reset(2);
    rx_q.delete(); d0 = done_cnt;
    repeat (320) step();
    trig = 1'b1;
    repeat (140) step();
    checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL hold_armed_in_dump: got %b expected 0", armed); end
    trig = 1'b0; step(); trig = 1'b1; repeat (3) step();
    trig = 1'b0; step(); trig = 1'b1;
    run_until_done(BUDGET);
    repeat (60) step();
    checks++; if (done_cnt != d0 + 1) begin errors++; $display("[TB] FAIL hold_single_capture: got %0d expected 1", done_cnt - d0); end
    checks++; if (rx_q.size() != 32) begin errors++; $display("[TB] FAIL hold_byte_count: got %0d expected 32", rx_q.size()); end
    checks++; if (armed !== 1'b1) begin errors++; $display("[TB] FAIL hold_still_armed: got %b expected 1", armed); end
    trig = 1'b0; step(); trig = 1'b1;
    run_until_done(BUDGET);
    checks++; if (done_cnt != d0 + 2) begin errors++; $display("[TB] FAIL hold_second_capture: got %0d expected 2", done_cnt - d0); end
    checks++; if (rx_q.size() != 64) begin errors++; $display("[TB] FAIL hold_second_bytes: got %0d expected 64", rx_q.size()); end
    trig = 1'b0;
  endtask

  task automatic test_reset_mid_dump();
    int d0, n_at_rst;
    busy_len = 100; hex_mode = 1'b0; pat_beef = 1'b0; decim = 8'd0;
    do_reset(2);
    rx_q.delete();
    repeat (320) step();
    trig = 1'b1;
    for (int i = 0; i < BUDGET && rx_q.size() < 5; i++) step();
    checks++; if (rx_q.size() < 5) begin errors++; $display("[TB] FAIL rstmid_dump_started: got %0d bytes expected 5", rx_q.size()); end
    d0 = done_cnt;
    do_reset(1);
    n_at_rst = rx_q.size();
    checks++; if (tx_if.tx_start !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_tx_start: got %b expected 0", tx_if.tx_start); end
    checks++; if (armed !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_armed: got %b expected 1", armed); end
    repeat (300) step();
    checks++; if (done_cnt != d0) begin errors++; $display("[TB] FAIL rstmid_no_done: got %0d expected 0", done_cnt - d0); end
    checks++; if (rx_q.size() != n_at_rst) begin errors++; $display("[TB] FAIL rstmid_no_tx: got %0d expected %0d", rx_q.size(), n_at_rst); end
    rx_q.delete();
    repeat (20) step();
    trig = 1'b1;
    run_until_done(BUDGET);
    checks++; if (done_cnt != d0 + 1) begin errors++; $display("[TB] FAIL rstmid_redump_done: got %0d expected 1", done_cnt - d0); end
    checks++; if (rx_q.size() != 32) begin errors++; $display("[TB] FAIL rstmid_redump_bytes: got %0d expected 32", rx_q.size()); end
    for (int i = 0; i < 16 && rx_q.size() == 32; i++) begin
      checks++; if ({rx_q[2*i], rx_q[2*i+1]} !== 16'(12 + i)) begin errors++; $display("[TB] FAIL rstmid_word[%0d]: got %h%h expected %h", i, rx_q[2*i], rx_q[2*i+1], 16'(12 + i)); end
    end
    trig = 1'b0; busy_len = 0;
  endtask

  initial begin
    test_reset();
    test_binary_dump();
    test_hex_dump();
    test_busy_handshake();
    test_decim();
    test_trig_hold();
    test_reset_mid_dump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
